// File: rtl/cpu_run_ctrl_pkg.sv
//------------------------------------------------------------------------------
// cpu_run_ctrl_pkg : shared state / halt-cause encodings for the run controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } run_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_INSTR = 2'd1,
      CAUSE_REQ   = 2'd2,
      CAUSE_WDOG  = 2'd3
   } halt_cause_e;

   // syscall encoding; the datapath never executes it
   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_000C;

endpackage : cpu_run_ctrl_pkg

`default_nettype wire

// File: rtl/cpu_run_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// cpu_run_ctrl_sat_counter : up-counter with clear and all-ones saturation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] base;

   // clear and increment together yield 1 (start of a fresh sequence)
   always_comb begin
      base    = clr_i ? '0 : count_q;
      count_d = base;
      if (inc_i && (base != '1)) begin
         count_d = base + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : cpu_run_ctrl_sat_counter

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// cpu_run_ctrl : program loader and run/halt/step/watchdog sequencer for the CPU
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 0,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ld_valid_i,
   input  logic [31:0]       ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_wa_o,
   output logic [31:0]       imem_wd_o,
   input  logic              run_req_i,
   input  logic              step_req_i,
   input  logic              halt_req_i,
   input  logic [31:0]       instr_i,
   output logic              cpu_reset_o,
   output logic              cpu_en_o,
   output logic [1:0]        state_o,
   output logic [1:0]        halt_cause_o,
   output logic [CNT_W-1:0]  cycle_count_o,
   output logic [ADDR_W:0]   load_count_o
);

   localparam logic [ADDR_W:0] LOAD_CAP   = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [CNT_W:0]  WDOG_LIMIT = (CNT_W+1)'(MAX_CYCLES);

   run_state_e        state_q;
   halt_cause_e       cause_q;
   logic [CNT_W-1:0]  cycle_count;
   logic [ADDR_W:0]   load_count;

   logic in_idle, in_load, in_run, in_halt;
   logic is_halt_instr, ld_ready, xfer, cpu_en, wdog_hit;
   logic cyc_clr, ld_clr;

   assign in_idle       = (state_q == ST_IDLE);
   assign in_load       = (state_q == ST_LOAD);
   assign in_run        = (state_q == ST_RUN);
   assign in_halt       = (state_q == ST_HALT);
   assign is_halt_instr = (instr_i == HALT_INSTR);

   // run_req in IDLE wins over a load word, so the word is refused rather than written
   assign ld_ready = !reset_i && (in_idle || in_load) && (load_count < LOAD_CAP)
                     && !(in_idle && run_req_i);
   assign xfer     = ld_valid_i && ld_ready;

   assign cpu_en = !reset_i && !halt_req_i && !is_halt_instr
                   && (in_run || (in_halt && step_req_i && !run_req_i));

   assign wdog_hit = (MAX_CYCLES != 0) && in_run && cpu_en
                     && (({1'b0, cycle_count} + (CNT_W+1)'(1)) >= WDOG_LIMIT);

   // a word taken in IDLE always starts a new program at address 0
   assign cyc_clr = in_idle && run_req_i;
   assign ld_clr  = (in_idle && xfer) || (in_halt && halt_req_i);

   cpu_run_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (cyc_clr),
      .inc_i   (cpu_en),
      .count_o (cycle_count)
   );

   cpu_run_ctrl_sat_counter #(
      .W (ADDR_W + 1)
   ) u_load_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (ld_clr),
      .inc_i   (xfer),
      .count_o (load_count)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_req_i) begin
                  state_q <= ST_RUN;
                  cause_q <= CAUSE_NONE;
               end else if (xfer && !ld_last_i) begin
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (xfer && ld_last_i) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (halt_req_i) begin
                  state_q <= ST_HALT;
                  cause_q <= CAUSE_REQ;
               end else if (is_halt_instr) begin
                  state_q <= ST_HALT;
                  cause_q <= CAUSE_INSTR;
               end else if (wdog_hit) begin
                  state_q <= ST_HALT;
                  cause_q <= CAUSE_WDOG;
               end
            end
            ST_HALT: begin
               if (halt_req_i) begin
                  state_q <= ST_IDLE;
               end else if (run_req_i) begin
                  state_q <= ST_RUN;
                  cause_q <= CAUSE_NONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ld_ready_o    = ld_ready;
   assign imem_we_o     = xfer;
   assign imem_wa_o     = in_load ? load_count[ADDR_W-1:0] : '0;
   assign imem_wd_o     = ld_data_i;
   assign cpu_reset_o   = reset_i || in_idle || in_load;
   assign cpu_en_o      = cpu_en;
   assign state_o       = state_q;
   assign halt_cause_o  = cause_q;
   assign cycle_count_o = cycle_count;
   assign load_count_o  = load_count;

endmodule : cpu_run_ctrl

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
//------------------------------------------------------------------------------
// tb_cpu_run_ctrl : directed + random bench for cpu_run_ctrl with a cycle model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_ctrl;

   localparam int          AW   = 2;
   localparam int          CW   = 3;
   localparam int          MAXC = 5;
   localparam int          CAP  = 4;
   localparam int          CMAX = 7;
   localparam logic [31:0] HI   = 32'h0000_000C;

   logic          clk = 1'b0;
   logic          reset, ld_valid, ld_last, run_req, step_req, halt_req;
   logic [31:0]   ld_data, instr;
   logic          ld_ready, imem_we, cpu_reset, cpu_en;
   logic [AW-1:0] imem_wa;
   logic [31:0]   imem_wd;
   logic [1:0]    state, halt_cause;
   logic [CW-1:0] cycle_count;
   logic [AW:0]   load_count;

   int vectors     = 0;
   int miscompares = 0;
   int en_seen     = 0;

   // reference model: mode 0 idle, 1 loading, 2 running, 3 halted
   int m_mode, m_cause, m_cyc, m_lc;

   always #5 clk = ~clk;

   cpu_run_ctrl #(
      .ADDR_W     (AW),
      .CNT_W      (CW),
      .MAX_CYCLES (MAXC),
      .HALT_INSTR (HI)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .ld_valid_i    (ld_valid),
      .ld_data_i     (ld_data),
      .ld_last_i     (ld_last),
      .ld_ready_o    (ld_ready),
      .imem_we_o     (imem_we),
      .imem_wa_o     (imem_wa),
      .imem_wd_o     (imem_wd),
      .run_req_i     (run_req),
      .step_req_i    (step_req),
      .halt_req_i    (halt_req),
      .instr_i       (instr),
      .cpu_reset_o   (cpu_reset),
      .cpu_en_o      (cpu_en),
      .state_o       (state),
      .halt_cause_o  (halt_cause),
      .cycle_count_o (cycle_count),
      .load_count_o  (load_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      reset    = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = 32'h0;
      run_req  = 1'b0;
      step_req = 1'b0;
      halt_req = 1'b0;
      instr    = 32'h2008_0005;
   endtask

   // one clock: check every output against the model, then advance the model
   task automatic tick();
      int rdy, xf, en, wa;
      #1;
      rdy = (!reset && (m_mode <= 1) && (m_lc < CAP) && !(m_mode == 0 && run_req)) ? 1 : 0;
      xf  = (rdy == 1 && ld_valid) ? 1 : 0;
      wa  = (m_mode == 1) ? m_lc : 0;
      en  = 0;
      if (!reset && !halt_req && instr != HI) begin
         if (m_mode == 2) en = 1;
         if (m_mode == 3 && step_req && !run_req) en = 1;
      end
      chk("ld_ready", ld_ready, rdy);
      chk("imem_we", imem_we, xf);
      if (xf == 1) chk("imem_wa", imem_wa, wa);
      chk("imem_wd", imem_wd, ld_data);
      chk("cpu_reset", cpu_reset, (reset || m_mode <= 1) ? 1 : 0);
      chk("cpu_en", cpu_en, en);
      chk("state", state, m_mode);
      chk("halt_cause", halt_cause, m_cause);
      chk("cycle_count", cycle_count, m_cyc);
      chk("load_count", load_count, m_lc);
      en_seen += en;
      @(posedge clk);
      if (reset) begin
         m_mode = 0; m_cause = 0; m_cyc = 0; m_lc = 0;
      end else begin
         if (en == 1 && m_cyc < CMAX) m_cyc++;
         case (m_mode)
            0: if (run_req) begin
                  m_mode = 2; m_cyc = 0; m_cause = 0;
               end else if (xf == 1) begin
                  m_lc = 1;
                  if (!ld_last) m_mode = 1;
               end
            1: if (xf == 1) begin
                  m_lc++;
                  if (ld_last) m_mode = 0;
               end
            2: if (halt_req) begin
                  m_mode = 3; m_cause = 2;
               end else if (instr == HI) begin
                  m_mode = 3; m_cause = 1;
               end else if (m_cyc >= MAXC) begin
                  m_mode = 3; m_cause = 3;
               end
            default: if (halt_req) begin
                  m_mode = 0; m_lc = 0;
               end else if (run_req) begin
                  m_mode = 2; m_cause = 0;
               end
         endcase
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] prog [3];
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_000A;
      prog[2] = 32'h0000_000C;

      clr_in();
      reset = 1'b1;
      @(negedge clk);
      m_mode = 0; m_cause = 0; m_cyc = 0; m_lc = 0;
      tick();
      reset = 1'b0;
      tick();
      chk("reset_state", state, 0);
      chk("reset_cpu_reset", cpu_reset, 1);

      // program load with ld_last on the third word
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
         tick();
      end
      clr_in();
      chk("t1_state", state, 0);
      chk("t1_load_count", load_count, 3);

      // run until the halt instruction
      run_req = 1'b1; tick(); run_req = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 3; i++) begin
         instr = prog[i]; tick();
      end
      chk("t2_state", state, 3);
      chk("t2_cause", halt_cause, 1);
      chk("t2_count", cycle_count, 2);
      chk("t2_en_cycles", en_seen, 2);

      // watchdog after exactly MAXC executed cycles
      instr = 32'h2008_0005;
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      run_req = 1'b1; tick(); run_req = 1'b0;
      en_seen = 0;
      repeat (8) begin
         instr = $urandom | 32'h8000_0000; tick();
      end
      chk("t3_state", state, 3);
      chk("t3_cause", halt_cause, 3);
      chk("t3_count", cycle_count, 5);
      chk("t3_en_cycles", en_seen, 5);

      // halt_req mid-run, two single steps, resume
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      run_req = 1'b1; tick(); run_req = 1'b0;
      tick(); tick();
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      chk("t4_cause", halt_cause, 2);
      chk("t4_count_before", cycle_count, 2);
      en_seen = 0;
      step_req = 1'b1; tick(); step_req = 1'b0; tick(); tick();
      step_req = 1'b1; tick(); step_req = 1'b0; tick();
      chk("t4_step_cycles", en_seen, 2);
      chk("t4_count_after", cycle_count, 4);
      run_req = 1'b1; tick(); run_req = 1'b0;
      chk("t4_resume_state", state, 2);
      chk("t4_resume_cause", halt_cause, 0);
      tick();
      chk("t4_wdog_state", state, 3);
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1; tick(); step_req = 1'b0; tick();
      end
      chk("t4_saturate", cycle_count, 7);

      // overfill a 4-word memory
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0; tick();
      end
      chk("t5_state", state, 1);
      chk("t5_load_count", load_count, 4);
      chk("t5_ld_ready", ld_ready, 0);
      clr_in();

      // reset during LOAD and during RUN
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_load_state", state, 0);
      chk("t6_load_lc", load_count, 0);
      chk("t6_load_cause", halt_cause, 0);
      run_req = 1'b1; tick(); run_req = 1'b0;
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_run_state", state, 0);
      chk("t6_run_cpu_en", cpu_en, 0);
      chk("t6_run_count", cycle_count, 0);
      run_req = 1'b1; tick(); run_req = 1'b0;
      halt_req = 1'b1; tick();
      run_req = 1'b1; tick();
      clr_in();
      chk("t6_both_req", state, 0);

      // resume onto a halt instruction re-halts with cause 1
      run_req = 1'b1; tick(); run_req = 1'b0;
      instr = HI; tick();
      run_req = 1'b1; tick(); run_req = 1'b0;
      chk("t7_resume_state", state, 2);
      tick();
      chk("t7_rehalt_cause", halt_cause, 1);
      clr_in();

      repeat (400) begin
         reset    = ($urandom_range(0, 49) == 0);
         ld_valid = $urandom_range(0, 1) == 1;
         ld_data  = $urandom;
         ld_last  = ($urandom_range(0, 3) == 0);
         run_req  = ($urandom_range(0, 7) == 0);
         step_req = ($urandom_range(0, 2) == 0);
         halt_req = ($urandom_range(0, 9) == 0);
         instr    = ($urandom_range(0, 5) == 0) ? HI : ($urandom | 32'h8000_0000);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_cpu_run_ctrl

`default_nettype wire
